// File: rtl/gardner_pkg.sv
// rtl/gardner_pkg.sv - shared state encoding, default loop gains and counter helper for the Gardner loop controller
package gardner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_TRACK   = 2'd3
  } state_t;

  localparam int SHIFT_ACQ_DEFAULT = 2;
  localparam int SHIFT_TRK_DEFAULT = 5;
  localparam int CNT_W             = 16;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/err_abs_sat.sv
// rtl/err_abs_sat.sv - saturating absolute value of a signed timing error sample
module err_abs_sat #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] x,
  output logic        [WIDTH-1:0] abs_val
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  // The most negative sample has no positive twin, so it clamps to the largest positive value.
  always_comb begin
    abs_val = $unsigned(x);
    if ($unsigned(x) == MIN_NEG) begin
      abs_val = MAX_POS;
    end else if (x[WIDTH-1]) begin
      abs_val = $unsigned(-x);
    end
  end

endmodule

// File: rtl/gardner_loop_ctrl.sv
// rtl/gardner_loop_ctrl.sv - acquisition/tracking supervisor that sets Gardner loop gain and corrector reset
module gardner_loop_ctrl
  import gardner_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SHIFT_ACQ   = SHIFT_ACQ_DEFAULT,
  parameter int SHIFT_TRK   = SHIFT_TRK_DEFAULT,
  parameter int LOCK_THR    = 1024,
  parameter int UNLOCK_THR  = 4096,
  parameter int LOCK_SYMS   = 64,
  parameter int UNLOCK_SYMS = 16,
  parameter int ACQ_TIMEOUT = 4096,
  parameter int FLUSH_CYC   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sym_strobe,
  input  logic signed [WIDTH-1:0] error_n,
  output logic [3:0]              gardner_shift,
  output logic                    corr_rst,
  output logic                    locked,
  output logic [1:0]              state_o,
  output logic                    timeout_p,
  output logic                    loss_p
);

  localparam logic [31:0] LOCK_THR_U    = 32'(LOCK_THR);
  localparam logic [31:0] UNLOCK_THR_U  = 32'(UNLOCK_THR);
  localparam logic [31:0] LOCK_SYMS_U   = 32'(LOCK_SYMS);
  localparam logic [31:0] UNLOCK_SYMS_U = 32'(UNLOCK_SYMS);
  localparam logic [31:0] ACQ_TIMEOUT_U = 32'(ACQ_TIMEOUT);
  localparam logic [31:0] FLUSH_CYC_U   = 32'(FLUSH_CYC);

  state_t           state, state_nx;
  logic [CNT_W-1:0] sym_cnt, sym_nx;
  logic [CNT_W-1:0] good_cnt, good_nx;
  logic [CNT_W-1:0] bad_cnt, bad_nx;
  logic [CNT_W-1:0] flush_cnt, flush_nx;
  logic             corr_rst_nx, locked_nx, timeout_nx, loss_nx;
  logic [3:0]       shift_nx;

  logic [WIDTH-1:0] abs_err;
  logic [31:0]      abs_ext;
  logic             is_good, is_bad;

  err_abs_sat #(.WIDTH(WIDTH)) u_abs (
    .x       (error_n),
    .abs_val (abs_err)
  );

  assign abs_ext = 32'(abs_err);
  assign is_good = abs_ext < LOCK_THR_U;
  assign is_bad  = abs_ext >= UNLOCK_THR_U;
  assign state_o = state;

  // Next state, counter updates and next registered outputs; enable=0 overrides everything.
  always_comb begin
    state_nx   = state;
    sym_nx     = sym_cnt;
    good_nx    = good_cnt;
    bad_nx     = bad_cnt;
    flush_nx   = flush_cnt;
    timeout_nx = 1'b0;
    loss_nx    = 1'b0;

    if (!enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_FLUSH;
        ST_FLUSH: begin
          if (32'(flush_cnt) + 32'd1 >= FLUSH_CYC_U) begin
            state_nx = ST_ACQUIRE;
          end else begin
            flush_nx = sat_inc(flush_cnt);
          end
        end
        ST_ACQUIRE: begin
          if (sym_strobe) begin
            sym_nx  = sat_inc(sym_cnt);
            good_nx = is_good ? sat_inc(good_cnt) : '0;
            if (32'(good_nx) == LOCK_SYMS_U) begin
              state_nx = ST_TRACK;
            end else if (32'(sym_nx) == ACQ_TIMEOUT_U) begin
              state_nx   = ST_FLUSH;
              timeout_nx = 1'b1;
            end
          end
        end
        ST_TRACK: begin
          if (sym_strobe) begin
            bad_nx = is_bad ? sat_inc(bad_cnt) : '0;
            if (32'(bad_nx) == UNLOCK_SYMS_U) begin
              state_nx = ST_FLUSH;
              loss_nx  = 1'b1;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end

    // Every state starts with fresh counters.
    if (state_nx != state) begin
      sym_nx   = '0;
      good_nx  = '0;
      bad_nx   = '0;
      flush_nx = '0;
    end

    corr_rst_nx = (state_nx == ST_IDLE) || (state_nx == ST_FLUSH);
    locked_nx   = (state_nx == ST_TRACK);
    shift_nx    = (state_nx == ST_TRACK) ? 4'(SHIFT_TRK) : 4'(SHIFT_ACQ);
  end

  // State, counters and all outputs are registered together so they move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sym_cnt       <= '0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      flush_cnt     <= '0;
      corr_rst      <= 1'b1;
      gardner_shift <= 4'(SHIFT_ACQ);
      locked        <= 1'b0;
      timeout_p     <= 1'b0;
      loss_p        <= 1'b0;
    end else begin
      state         <= state_nx;
      sym_cnt       <= sym_nx;
      good_cnt      <= good_nx;
      bad_cnt       <= bad_nx;
      flush_cnt     <= flush_nx;
      corr_rst      <= corr_rst_nx;
      gardner_shift <= shift_nx;
      locked        <= locked_nx;
      timeout_p     <= timeout_nx;
      loss_p        <= loss_nx;
    end
  end

endmodule

// File: tb/tb_gardner_loop_ctrl.sv
// tb/tb_gardner_loop_ctrl.sv - self-checking bench for gardner_loop_ctrl against a behavioural model
module tb_gardner_loop_ctrl;

  localparam int T_LOCK_THR    = 1024;
  localparam int T_UNLOCK_THR  = 4096;
  localparam int T_LOCK_SYMS   = 64;
  localparam int T_UNLOCK_SYMS = 16;
  localparam int T_ACQ_TIMEOUT = 4096;
  localparam int T_FLUSH_CYC   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               sym_strobe;
  logic signed [15:0] error_n;
  logic [3:0]         gardner_shift;
  logic               corr_rst;
  logic               locked;
  logic [1:0]         state_o;
  logic               timeout_p;
  logic               loss_p;

  int checks   = 0;
  int failures = 0;

  int m_st, m_sym, m_good, m_bad, m_fl;
  bit m_to, m_loss;

  always #5 clk = ~clk;

  gardner_loop_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sym_strobe    (sym_strobe),
    .error_n       (error_n),
    .gardner_shift (gardner_shift),
    .corr_rst      (corr_rst),
    .locked        (locked),
    .state_o       (state_o),
    .timeout_p     (timeout_p),
    .loss_p        (loss_p)
  );

  function automatic int abs_sat(int e);
    int a;
    a = (e < 0) ? -e : e;
    return (a > 32767) ? 32767 : a;
  endfunction

  function automatic int inc_sat(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit s, input int d);
    int prev;
    prev   = m_st;
    m_to   = 1'b0;
    m_loss = 1'b0;
    if (r) begin
      m_st = 0; m_sym = 0; m_good = 0; m_bad = 0; m_fl = 0;
    end else begin
      if (!e) m_st = 0;
      else begin
        case (m_st)
          0: m_st = 1;
          1: begin
            m_fl = m_fl + 1;
            if (m_fl >= T_FLUSH_CYC) m_st = 2;
          end
          2: if (s) begin
            m_sym  = inc_sat(m_sym);
            m_good = (abs_sat(d) < T_LOCK_THR) ? inc_sat(m_good) : 0;
            if (m_good == T_LOCK_SYMS) m_st = 3;
            else if (m_sym == T_ACQ_TIMEOUT) begin m_st = 1; m_to = 1'b1; end
          end
          default: if (s) begin
            m_bad = (abs_sat(d) >= T_UNLOCK_THR) ? inc_sat(m_bad) : 0;
            if (m_bad == T_UNLOCK_SYMS) begin m_st = 1; m_loss = 1'b1; end
          end
        endcase
      end
      if (m_st != prev) begin
        m_sym = 0; m_good = 0; m_bad = 0; m_fl = 0;
      end
    end
  endtask

  function automatic logic [9:0] exp_vec();
    return {2'(m_st), (m_st < 2), ((m_st == 3) ? 4'd5 : 4'd2), (m_st == 3), m_to, m_loss};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {state_o, corr_rst, gardner_shift, locked, timeout_p, loss_p};
  endfunction

  task automatic tick(input bit r, input bit e, input bit s, input int d);
    rst        = r;
    enable     = e;
    sym_strobe = s;
    error_n    = 16'(d);
    @(posedge clk);
    model_step(r, e, s, d);
    #1;
  endtask

  function automatic int good_err();
    case ($urandom_range(0, 4))
      0: return 1023;
      1: return -1023;
      2: return 100;
      default: return int'($urandom_range(0, 2046)) - 1023;
    endcase
  endfunction

  function automatic int bad_err();
    case ($urandom_range(0, 5))
      0: return 4096;
      1: return -4096;
      2: return -32768;
      3: return 32767;
      4: return 5000;
      default: return int'($urandom_range(4096, 32767)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
    endcase
  endfunction

  // Reset, enable and walk through FLUSH into ACQUIRE; returns 1 once ACQUIRE is reached.
  task automatic bring_up(output bit ok);
    ok = 1'b0;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(0, 1, $urandom_range(0, 1), bad_err());
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bring_up cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      if (state_o == 2'd2) ok = 1'b1;
    end
    if (!ok) begin
      failures++;
      $display("FAIL bring_up_timeout got_state=%0d exp_state=2", state_o);
    end
  endtask

  task automatic test_reset();
    tick(1, 1, 1, 5000);
    tick(1, 1, 1, 100);
    checks++;
    if (obs_vec() !== {2'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs_vec(), {2'd0, 1'b1, 4'd2, 3'b000});
    end
  endtask

  task automatic test_flush();
    int flush_len;
    bit reached;
    flush_len = 0;
    reached   = 1'b0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 12 && !reached; i++) begin
      tick(0, 1, $urandom_range(0, 1), 100);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL flush_cycle cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      if (state_o == 2'd1 && corr_rst) flush_len++;
      if (state_o == 2'd2) reached = 1'b1;
    end
    checks++;
    if (flush_len != 4 || !reached || gardner_shift !== 4'd2 || corr_rst !== 1'b0) begin
      failures++;
      $display("FAIL flush_len got=%0d/%0b shift=%0d rst=%b exp=4/1 shift=2 rst=0",
               flush_len, reached, gardner_shift, corr_rst);
    end
  endtask

  task automatic test_lock();
    bit ok;
    bring_up(ok);
    for (int n = 1; n <= 64; n++) begin
      if ($urandom_range(0, 2) == 0) tick(0, 1, 0, 30000);
      tick(0, 1, 1, (n == 1) ? 100 : good_err());
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL lock_strobe n=%0d got=%b exp=%b", n, obs_vec(), exp_vec());
      end
      if (n == 63) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL lock_early got=%b exp=0", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || gardner_shift !== 4'd5 || state_o !== 2'd3) begin
      failures++;
      $display("FAIL lock_64 got=%b/%0d/%0d exp=1/5/3", locked, gardner_shift, state_o);
    end
  endtask

  task automatic test_glitch();
    bit ok;
    bring_up(ok);
    for (int n = 1; n <= 128; n++) begin
      tick(0, 1, 1, (n == 64) ? 2000 : good_err());
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL glitch_strobe n=%0d got=%b exp=%b", n, obs_vec(), exp_vec());
      end
      if (n == 127) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL glitch_early got=%b exp=0", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL glitch_lock128 got=%b exp=1", locked);
    end
  endtask

  task automatic test_track_loss();
    test_lock();
    for (int n = 1; n <= 16; n++) begin
      tick(0, 1, 1, (n == 16) ? good_err() : bad_err());
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL track_hold n=%0d got=%b exp=%b", n, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (state_o !== 2'd3 || locked !== 1'b1) begin
      failures++;
      $display("FAIL track_15bad got=%0d/%b exp=3/1", state_o, locked);
    end
    for (int n = 1; n <= 16; n++) begin
      tick(0, 1, 1, (n == 1) ? 5000 : bad_err());
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL track_loss n=%0d got=%b exp=%b", n, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (loss_p !== 1'b1 || locked !== 1'b0 || state_o !== 2'd1 || corr_rst !== 1'b1) begin
      failures++;
      $display("FAIL loss_16 got=%b/%b/%0d exp=1/0/1", loss_p, locked, state_o);
    end
    tick(0, 1, 0, 0);
    checks++;
    if (loss_p !== 1'b0) begin
      failures++;
      $display("FAIL loss_pulse_width got=%b exp=0", loss_p);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bring_up(ok);
    for (int n = 1; n <= 4096; n++) begin
      tick(0, 1, 1, -32768);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL timeout_strobe n=%0d got=%b exp=%b", n, obs_vec(), exp_vec());
      end
      if (n == 4095) begin
        checks++;
        if (state_o !== 2'd2 || timeout_p !== 1'b0) begin
          failures++;
          $display("FAIL timeout_early got=%0d/%b exp=2/0", state_o, timeout_p);
        end
      end
    end
    checks++;
    if (timeout_p !== 1'b1 || state_o !== 2'd1 || corr_rst !== 1'b1) begin
      failures++;
      $display("FAIL timeout_4096 got=%b/%0d exp=1/1", timeout_p, state_o);
    end
    tick(0, 1, 0, 0);
    checks++;
    if (timeout_p !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width got=%b exp=0", timeout_p);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    bring_up(ok);
    for (int n = 1; n <= 63; n++) tick(0, 1, 1, good_err());
    tick(0, 0, 1, 100);
    checks++;
    if (obs_vec() !== {2'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0} || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL enable_drop got=%b exp=%b", obs_vec(), {2'd0, 1'b1, 4'd2, 3'b000});
    end
  endtask

  task automatic test_rst_mid();
    test_lock();
    tick(1, 1, 1, 5000);
    checks++;
    if (obs_vec() !== {2'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid got=%b exp=%b", obs_vec(), {2'd0, 1'b1, 4'd2, 3'b000});
    end
  endtask

  task automatic test_random();
    int mode;
    int d;
    bit e, r, s;
    tick(1, 0, 0, 0);
    mode = 0;
    for (int i = 0; i < 6000; i++) begin
      if (i % 150 == 0) mode = $urandom_range(0, 2);
      r = ($urandom_range(0, 999) < 2);
      e = ($urandom_range(0, 999) >= 8);
      s = ($urandom_range(0, 3) != 0);
      case (mode)
        0: d = good_err();
        1: d = bad_err();
        default: d = ($urandom_range(0, 1) == 1) ? good_err() : int'($urandom_range(0, 65535)) - 32768;
      endcase
      tick(r, e, s, d);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    sym_strobe = 1'b0;
    error_n    = '0;
    m_st = 0; m_sym = 0; m_good = 0; m_bad = 0; m_fl = 0;
    m_to = 1'b0; m_loss = 1'b0;
    test_reset();
    test_flush();
    test_lock();
    test_glitch();
    test_track_loss();
    test_timeout();
    test_enable_drop();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
